mod_n_down_timer: RTL and testbench

//  - Real-time MM:SS countdown timer: the down-counting counterpart of the mod-N up-counting clock chain.
//  - Loads a BCD preset, then decrements once per second from an internal prescaler.
//  - Cascades mod-10 / mod-6 digits with borrow, and flags expiry at 00:00.
//  - Sits beside the up-counter; drives the same 4-digit BCD display path.

---
 rtl/timer_pkg.sv | 21 ++
 rtl/bcd_down_digit.sv | 28 ++
 rtl/mod_n_down_timer.sv | 104 ++++++++++
 tb/tb_mod_n_down_timer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and digit limits for the MM:SS countdown timer
package timer_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t ONES_MAX     = 4'd9;
  localparam bcd_t MIN_TENS_MAX = 4'd5;

  function automatic bcd_t clamp_bcd(input bcd_t v, input bcd_t max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD digit counting down 0..MAX with borrow out
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter bcd_t MAX = ONES_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic ld,
  input  bcd_t ld_val,
  input  logic dec,
  output bcd_t value,
  output logic borrow_out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (ld) begin
      value <= clamp_bcd(ld_val, MAX);
    end else if (dec) begin
      value <= (value == '0) ? MAX : value - 4'd1;
    end
  end

  assign borrow_out = dec && (value == '0);

endmodule

// File: rtl/mod_n_down_timer.sv
// rtl/mod_n_down_timer.sv - MM:SS BCD countdown timer with 1 s prescaler and expiry flag
module mod_n_down_timer
  import timer_pkg::*;
#(
  parameter int CLK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] preset_min_tens,
  input  logic [3:0] preset_min_ones,
  input  logic [3:0] preset_sec_tens,
  input  logic [3:0] preset_sec_ones,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       tick,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  timer_state_t  state, state_nxt;
  logic [PW-1:0] presc;
  logic          tick_fire;
  logic          is_zero, is_one;
  logic          dec_so;
  logic          b_so, b_st, b_mo, b_mt;

  assign is_zero = (min_tens == '0) && (min_ones == '0) && (sec_tens == '0) && (sec_ones == '0);
  assign is_one  = (min_tens == '0) && (min_ones == '0) && (sec_tens == '0) && (sec_ones == 4'd1);

  // A tick that collides with reset, load or stop is dropped so nothing it implies gets committed.
  assign tick_fire = (state == RUN) && (presc == PRESC_LAST) && !reset && !load && !stop;
  assign dec_so    = tick_fire && !is_zero;

  assign tick    = tick_fire;
  assign running = (state == RUN);
  assign expired = (state == DONE);

  bcd_down_digit #(.MAX(ONES_MAX)) u_sec_ones (
    .clk(clk), .reset(reset), .ld(load), .ld_val(preset_sec_ones),
    .dec(dec_so), .value(sec_ones), .borrow_out(b_so)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .reset(reset), .ld(load), .ld_val(preset_sec_tens),
    .dec(b_so), .value(sec_tens), .borrow_out(b_st)
  );

  bcd_down_digit #(.MAX(ONES_MAX)) u_min_ones (
    .clk(clk), .reset(reset), .ld(load), .ld_val(preset_min_ones),
    .dec(b_st), .value(min_ones), .borrow_out(b_mo)
  );

  bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk(clk), .reset(reset), .ld(load), .ld_val(preset_min_tens),
    .dec(b_mo), .value(min_tens), .borrow_out(b_mt)
  );

  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, PAUSED: if (start && !stop && !is_zero) state_nxt = RUN;
        // b_mt would mean a wrap past 00:00; treat it as expiry rather than counting on.
        RUN: begin
          if (stop)                                 state_nxt = PAUSED;
          else if (tick_fire && (is_one || b_mt))   state_nxt = DONE;
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == RUN) && (state_nxt == DONE);
    end
  end

  // IDLE always holds the prescaler at 0, so a fresh start begins a full second; a resume keeps the partial count.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      presc <= '0;
    end else if ((state == RUN) && !stop) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

endmodule

// File: tb/tb_mod_n_down_timer.sv
// tb/tb_mod_n_down_timer.sv - scoreboard bench for the MM:SS countdown timer
module tb_mod_n_down_timer;

  logic       clk = 1'b0;
  logic       reset, load, start, stop;
  logic [3:0] pmt, pmo, pst, pso;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       tick, running, done, expired;

  localparam logic [3:0] F_IDLE = 4'b0000;
  localparam logic [3:0] F_RUN  = 4'b0100;
  localparam logic [3:0] F_TICK = 4'b1100;
  localparam logic [3:0] F_DONE = 4'b0011;
  localparam logic [3:0] F_EXP  = 4'b0001;

  typedef struct {
    int          at;
    logic [15:0] dig;
    logic [3:0]  flg;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cnt = 0;
  int   checks = 0;
  int   errors = 0;

  mod_n_down_timer #(.CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .load(load),
    .preset_min_tens(pmt), .preset_min_ones(pmo),
    .preset_sec_tens(pst), .preset_sec_ones(pso),
    .start(start), .stop(stop),
    .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones),
    .tick(tick), .running(running), .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cnt) begin
      e = q.pop_front();
      checks++;
      if (e.at < cnt ||
          {min_tens, min_ones, sec_tens, sec_ones} !== e.dig ||
          {tick, running, done, expired} !== e.flg) begin
        errors++;
        $display("FAIL %s @%0d: got %h flags(t,r,d,e)=%b, expected %h flags %b (due %0d)",
                 e.name, cnt, {min_tens, min_ones, sec_tens, sec_ones},
                 {tick, running, done, expired}, e.dig, e.flg, e.at);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int dt, input logic [15:0] dig, input logic [3:0] flg, input string name);
    exp_t x;
    x.at   = cnt + dt;
    x.dig  = dig;
    x.flg  = flg;
    x.name = name;
    q.push_back(x);
  endtask

  task automatic do_load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    pmt  = a;
    pmo  = b;
    pst  = c;
    pso  = d;
    load = 1'b1;
    next();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
    pmt = '0; pmo = '0; pst = '0; pso = '0;
    next();
    next();

    // reset state, start at 00:00 is ignored
    push(0, 16'h0000, F_IDLE, "reset_state");
    reset = 1'b0;
    start = 1'b1;
    push(1, 16'h0000, F_IDLE, "start_at_zero");
    push(3, 16'h0000, F_IDLE, "start_at_zero_later");
    next();
    start = 1'b0;
    repeat (3) next();

    // 01:00 countdown, min_ones borrow
    do_load(4'd0, 4'd1, 4'd0, 4'd0);
    push(0, 16'h0100, F_IDLE, "t2_loaded");
    start = 1'b1;
    push(1, 16'h0100, F_RUN,  "t2_running");
    push(3, 16'h0100, F_RUN,  "t2_pre_tick");
    push(4, 16'h0100, F_TICK, "t2_first_tick");
    push(5, 16'h0059, F_RUN,  "t2_0059");
    push(8, 16'h0059, F_TICK, "t2_second_tick");
    push(9, 16'h0058, F_RUN,  "t2_0058");
    next();
    start = 1'b0;
    repeat (9) next();

    // 00:02 expiry
    do_load(4'd0, 4'd0, 4'd0, 4'd2);
    push(0, 16'h0002, F_IDLE, "t3_loaded");
    start = 1'b1;
    push(4, 16'h0002, F_TICK, "t3_tick1");
    push(5, 16'h0001, F_RUN,  "t3_0001");
    push(8, 16'h0001, F_TICK, "t3_tick2");
    push(9, 16'h0000, F_DONE, "t3_done_pulse");
    push(10, 16'h0000, F_EXP, "t3_expired_level");
    next();
    start = 1'b0;
    repeat (11) next();
    start = 1'b1;
    push(1, 16'h0000, F_EXP, "t3_start_ignored");
    push(3, 16'h0000, F_EXP, "t3_still_expired");
    next();
    start = 1'b0;
    repeat (3) next();

    // pause / resume keeps partial prescaler count
    do_load(4'd0, 4'd0, 4'd1, 4'd0);
    start = 1'b1;
    push(1, 16'h0010, F_RUN, "t4_running");
    next();
    start = 1'b0;
    next();
    stop = 1'b1;
    push(1, 16'h0010, F_IDLE, "t4_paused");
    push(10, 16'h0010, F_IDLE, "t4_paused_mid");
    push(20, 16'h0010, F_IDLE, "t4_paused_end");
    next();
    stop = 1'b0;
    repeat (20) next();
    start = 1'b1;
    push(1, 16'h0010, F_RUN,  "t4_resumed");
    push(2, 16'h0010, F_RUN,  "t4_no_early_tick");
    push(3, 16'h0010, F_TICK, "t4_tick_remaining");
    push(4, 16'h0009, F_RUN,  "t4_sec_tens_borrow");
    next();
    start = 1'b0;
    repeat (4) next();

    // clamping and 10:00 -> 09:59
    do_load(4'd9, 4'hF, 4'd7, 4'hF);
    push(0, 16'h5959, F_IDLE, "t5_clamp");
    next();
    do_load(4'd1, 4'd0, 4'd0, 4'd0);
    push(0, 16'h1000, F_IDLE, "t5_loaded");
    start = 1'b1;
    push(4, 16'h1000, F_TICK, "t5_tick");
    push(5, 16'h0959, F_RUN,  "t5_full_borrow");
    next();
    start = 1'b0;
    repeat (7) next();

    // load coinciding with a tick, then mid-run reset
    push(0, 16'h0959, F_RUN, "t6_tick_discarded");
    do_load(4'd0, 4'd3, 4'd0, 4'd0);
    push(0, 16'h0300, F_IDLE, "t6_loaded");
    start = 1'b1;
    push(1, 16'h0300, F_RUN, "t6_no_dec");
    next();
    start = 1'b0;
    next();
    reset = 1'b1;
    push(0, 16'h0300, F_RUN,  "t6_before_reset");
    push(1, 16'h0000, F_IDLE, "t6_reset");
    next();
    reset = 1'b0;
    push(3, 16'h0000, F_IDLE, "t6_stay_zero");
    repeat (4) next();

    for (int i = 0; i < 200 && q.size() > 0; i++) next();
    if (q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
